// File: rtl/wb_trace_monitor.sv
// Write-back trace monitor: timestamps register write-backs into a circular
// first-word-fall-through FIFO, counts RUN cycles, and ends a run on a
// branch-to-self halt or when the cycle budget runs out.
module wb_trace_monitor #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned PC_W        = 32,
  parameter int unsigned REG_W       = 4,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT     = 100,
  parameter int unsigned HALT_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     clr,
  input  logic [PC_W-1:0]          pc,
  input  logic                     wb_en,
  input  logic [REG_W-1:0]         wb_rd,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     trace_pop,
  output logic                     trace_valid,
  output logic [CNT_W-1:0]         trace_cycle,
  output logic [REG_W-1:0]         trace_rd,
  output logic [DATA_W-1:0]        trace_data,
  output logic [$clog2(DEPTH):0]   trace_count,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [CNT_W-1:0]         cycle_cnt,
  output logic [1:0]               state,
  output logic                     done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  // Wide enough to hold HALT_CYCLES itself, so HALT_CYCLES=1 still works.
  localparam int unsigned SW = $clog2(HALT_CYCLES + 1);
  localparam int unsigned EW = CNT_W + REG_W + DATA_W;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StHalted  = 2'd2,
    StTimeout = 2'd3
  } state_e;

  state_e              r_state;
  logic                r_done;
  logic [PC_W-1:0]     r_pc;
  logic [SW-1:0]       r_stable;
  logic [CNT_W-1:0]    r_cycle;
  logic [CNT_W-1:0]    r_drop;
  logic                r_overflow;
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [CW-1:0]       r_count;
  logic [EW-1:0]       r_mem [DEPTH];

  logic w_run;
  logic w_pc_same;
  logic w_halt_hit;
  logic w_timeout_hit;
  logic w_push;
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_write;
  logic w_drop;
  logic [EW-1:0] w_head;

  assign w_run         = (r_state == StRun);
  assign w_pc_same     = (pc == r_pc);
  assign w_halt_hit    = w_run && w_pc_same && (r_stable == SW'(HALT_CYCLES - 1));
  assign w_timeout_hit = w_run && (r_cycle == CNT_W'(TIMEOUT - 1));
  assign w_push        = w_run && wb_en && !clr;
  assign w_full        = (r_count == CW'(DEPTH));
  assign w_empty       = (r_count == '0);
  assign w_pop         = trace_pop && !w_empty && !clr;
  // A pop on a full FIFO frees the slot the push lands in on the same edge.
  assign w_write       = w_push && (!w_full || w_pop);
  assign w_drop        = w_push && w_full && !w_pop;

  // Run-control FSM: cycle counting, halt detection and terminal states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_done   <= 1'b0;
      r_pc     <= '0;
      r_stable <= '0;
      r_cycle  <= '0;
    end else if (clr) begin
      r_state  <= StIdle;
      r_done   <= 1'b0;
      r_pc     <= pc;
      r_stable <= '0;
      r_cycle  <= '0;
    end else begin
      r_pc <= pc;
      case (r_state)
        StIdle: begin
          r_stable <= '0;
          if (start) begin
            r_state <= StRun;
          end
        end
        StRun: begin
          r_cycle  <= r_cycle + 1'b1;
          r_stable <= w_pc_same ? r_stable + 1'b1 : '0;
          // Halt takes precedence over timeout on the same edge.
          if (w_halt_hit) begin
            r_state <= StHalted;
            r_done  <= 1'b1;
          end else if (w_timeout_hit) begin
            r_state <= StTimeout;
            r_done  <= 1'b1;
          end
        end
        StHalted: ;
        StTimeout: ;
        default: r_state <= StIdle;
      endcase
    end
  end

  // FIFO pointers, occupancy and drop accounting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drop     <= '0;
    end else if (clr) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drop     <= '0;
    end else begin
      if (w_write) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop != {CNT_W{1'b1}}) begin
          r_drop <= r_drop + 1'b1;
        end
      end
    end
  end

  // Trace storage; contents are meaningless while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wptr] <= {r_cycle, wb_rd, wb_data};
    end
  end

  assign w_head      = r_mem[r_rptr];
  assign trace_valid = !w_empty;
  assign trace_cycle = w_head[EW-1 -: CNT_W];
  assign trace_rd    = w_head[DATA_W +: REG_W];
  assign trace_data  = w_head[DATA_W-1:0];
  assign trace_count = r_count;
  assign overflow    = r_overflow;
  assign drop_cnt    = r_drop;
  assign cycle_cnt   = r_cycle;
  assign state       = r_state;
  assign done        = r_done;

endmodule

// File: tb/tb_wb_trace_monitor.sv
// Bench for wb_trace_monitor: directed scenarios plus random runs, every cycle
// compared against a queue-based reference model of the trace monitor.
module tb_wb_trace_monitor;

  localparam int DATA_W      = 32;
  localparam int PC_W        = 32;
  localparam int REG_W       = 4;
  localparam int DEPTH       = 16;
  localparam int CNT_W       = 16;
  localparam int TIMEOUT     = 100;
  localparam int HALT_CYCLES = 4;
  localparam int CW          = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              clr;
  logic [PC_W-1:0]   pc;
  logic              wb_en;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              trace_pop;
  logic              trace_valid;
  logic [CNT_W-1:0]  trace_cycle;
  logic [REG_W-1:0]  trace_rd;
  logic [DATA_W-1:0] trace_data;
  logic [CW-1:0]     trace_count;
  logic              overflow;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [1:0]        state;
  logic              done;

  wb_trace_monitor #(
    .DATA_W(DATA_W), .PC_W(PC_W), .REG_W(REG_W), .DEPTH(DEPTH),
    .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .HALT_CYCLES(HALT_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .clr(clr), .pc(pc),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .trace_pop(trace_pop),
    .trace_valid(trace_valid), .trace_cycle(trace_cycle), .trace_rd(trace_rd),
    .trace_data(trace_data), .trace_count(trace_count), .overflow(overflow),
    .drop_cnt(drop_cnt), .cycle_cnt(cycle_cnt), .state(state), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: trace as a queue of entries, run status as plain integers.
  typedef struct {
    int unsigned cyc;
    int unsigned rd;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];
  int          m_state;
  int          m_cycle;
  int          m_stable;
  int          m_drop;
  bit          m_ovf;
  logic [31:0] m_pc;

  int n_checks = 0;
  int n_fail   = 0;
  bit pc_walk  = 1'b1;

  logic [3:0]  b_en = 4'b1101;
  int          b_rd[4]   = '{1, 0, 2, 3};
  logic [31:0] b_data[4] = '{32'hA, 32'h0, 32'hB, 32'hC};
  int          exp_ts[3] = '{0, 2, 3};
  int          exp_rd[3] = '{1, 2, 3};
  logic [31:0] exp_d[3]  = '{32'hA, 32'hB, 32'hC};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_state  = 0;
    m_cycle  = 0;
    m_stable = 0;
    m_drop   = 0;
    m_ovf    = 1'b0;
    m_pc     = '0;
  endtask

  // Apply one clock edge of the specified behaviour to the model.
  task automatic model_edge();
    bit   do_pop;
    bit   do_push;
    bit   full;
    bit   same;
    bit   halt;
    bit   tmo;
    ent_t e;
    if (reset) begin
      model_reset();
      return;
    end
    if (clr) begin
      model_reset();
      m_pc = pc;
      return;
    end
    do_pop  = trace_pop && (m_q.size() > 0);
    do_push = (m_state == 1) && wb_en;
    full    = (m_q.size() == DEPTH);
    if (do_push && full && !do_pop) begin
      m_ovf = 1'b1;
      if (m_drop < (1 << CNT_W) - 1) m_drop++;
    end
    if (do_pop) void'(m_q.pop_front());
    if (do_push && !(full && !do_pop)) begin
      e.cyc  = m_cycle;
      e.rd   = wb_rd;
      e.data = wb_data;
      m_q.push_back(e);
    end
    if (m_state == 0) begin
      m_stable = 0;
      if (start) m_state = 1;
    end else if (m_state == 1) begin
      same     = (pc == m_pc);
      halt     = same && (m_stable == HALT_CYCLES - 1);
      tmo      = (m_cycle == TIMEOUT - 1);
      m_stable = same ? m_stable + 1 : 0;
      m_cycle++;
      if (halt) m_state = 2;
      else if (tmo) m_state = 3;
    end
    m_pc = pc;
  endtask

  task automatic check_all();
    chk("state", 64'(state), 64'(m_state));
    chk("done", 64'(done), 64'(m_state >= 2));
    chk("cycle_cnt", 64'(cycle_cnt), 64'(m_cycle));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("trace_valid", 64'(trace_valid), 64'(m_q.size() > 0));
    chk("trace_count", 64'(trace_count), 64'(m_q.size()));
    if (m_q.size() > 0) begin
      chk("head_cycle", 64'(trace_cycle), 64'(m_q[0].cyc));
      chk("head_rd", 64'(trace_rd), 64'(m_q[0].rd));
      chk("head_data", 64'(trace_data), 64'(m_q[0].data));
    end
  endtask

  // One clock edge: model follows, outputs checked 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (pc_walk) pc = pc + 32'd4;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; clr = 1'b0; pc = '0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0; trace_pop = 1'b0;
    model_reset();
    #2;
    check_all();
    step();
    reset = 1'b0;

    // Basic capture and pop order.
    start = 1'b1; step(); start = 1'b0;
    chk("basic_running", 64'(state), 64'd1);
    for (int k = 0; k < 4; k++) begin
      wb_en = b_en[k]; wb_rd = REG_W'(b_rd[k]); wb_data = b_data[k];
      step();
    end
    wb_en = 1'b0;
    for (int p = 0; p < 3; p++) begin
      chk("basic_head_ts", 64'(trace_cycle), 64'(exp_ts[p]));
      chk("basic_head_rd", 64'(trace_rd), 64'(exp_rd[p]));
      chk("basic_head_data", 64'(trace_data), 64'(exp_d[p]));
      trace_pop = 1'b1; step();
    end
    trace_pop = 1'b0;
    chk("basic_empty", 64'(trace_valid), 64'd0);
    trace_pop = 1'b1; step(); trace_pop = 1'b0;
    clr = 1'b1; step(); clr = 1'b0;

    // Overflow, then push+pop on a full FIFO.
    start = 1'b1; step(); start = 1'b0;
    wb_en = 1'b1;
    for (int k = 0; k < 18; k++) begin
      wb_rd = REG_W'(k); wb_data = $urandom; step();
    end
    chk("ovf_count", 64'(trace_count), 64'd16);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_drop", 64'(drop_cnt), 64'd2);
    chk("ovf_head_ts", 64'(trace_cycle), 64'd0);
    trace_pop = 1'b1; step(); wb_en = 1'b0;
    chk("fullpp_count", 64'(trace_count), 64'd16);
    chk("fullpp_drop", 64'(drop_cnt), 64'd2);
    for (int k = 0; k < 14; k++) step();
    trace_pop = 1'b0;
    chk("ovf_last_ts", 64'(trace_cycle), 64'd15);
    clr = 1'b1; start = 1'b1; step(); clr = 1'b0; start = 1'b0;
    chk("clr_start_state", 64'(state), 64'd0);
    chk("clr_start_valid", 64'(trace_valid), 64'd0);
    chk("clr_start_ovf", 64'(overflow), 64'd0);

    // Halt: PC walks to 0x20 and sticks there.
    pc_walk = 1'b0; pc = '0;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      pc = 32'(4 * k); step();
    end
    for (int r = 1; r <= 4; r++) begin
      step();
      chk("halt_progress", 64'(state), (r < 4) ? 64'd1 : 64'd2);
    end
    chk("halt_done", 64'(done), 64'd1);
    chk("halt_cycles", 64'(cycle_cnt), 64'd12);
    wb_en = 1'b1; step(); step(); wb_en = 1'b0;
    chk("halt_no_capture", 64'(trace_count), 64'd0);
    chk("halt_frozen", 64'(cycle_cnt), 64'd12);
    start = 1'b1; step(); start = 1'b0;
    chk("halt_start_ignored", 64'(state), 64'd2);
    pc_walk = 1'b1;
    clr = 1'b1; step(); clr = 1'b0;

    // Timeout with a push on the final RUN cycle.
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      wb_en = (k == 99); wb_rd = 4'd5; wb_data = 32'hDEAD_BEEF;
      step();
      if (k == 98) chk("tmo_still_run", 64'(state), 64'd1);
    end
    wb_en = 1'b0;
    chk("tmo_state", 64'(state), 64'd3);
    chk("tmo_cycles", 64'(cycle_cnt), 64'd100);
    chk("tmo_count", 64'(trace_count), 64'd1);
    chk("tmo_last_ts", 64'(trace_cycle), 64'd99);
    clr = 1'b1; step(); clr = 1'b0;

    // Halt completes on the same edge as cycle 99.
    pc_walk = 1'b0; pc = '0;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      pc = (k <= 95) ? 32'(4 * (k + 1)) : 32'(4 * 96);
      step();
    end
    chk("tie_state", 64'(state), 64'd2);
    chk("tie_cycles", 64'(cycle_cnt), 64'd100);
    clr = 1'b1; step(); clr = 1'b0;

    // Random runs with sticky PCs, random pops, occasional clr/start.
    for (int r = 0; r < 4; r++) begin
      start = 1'b1; step(); start = 1'b0;
      for (int c = 0; c < 130; c++) begin
        wb_en     = 1'($urandom_range(0, 1));
        trace_pop = ($urandom_range(0, 2) == 0);
        wb_rd     = REG_W'($urandom);
        wb_data   = $urandom;
        if ($urandom_range(0, 3) == 0) pc = {$urandom_range(0, 1023), 2'b00};
        start     = ($urandom_range(0, 7) == 0);
        clr       = ($urandom_range(0, 59) == 0);
        step();
      end
      wb_en = 1'b0; trace_pop = 1'b0; start = 1'b0;
      clr = 1'b1; step(); clr = 1'b0;
    end
    pc_walk = 1'b1;

    // Asynchronous reset between edges in the middle of a run.
    start = 1'b1; step(); start = 1'b0;
    wb_en = 1'b1; step(); step(); step(); wb_en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("areset_state", 64'(state), 64'd0);
    chk("areset_valid", 64'(trace_valid), 64'd0);
    chk("areset_cycles", 64'(cycle_cnt), 64'd0);
    step();
    reset = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    wb_en = 1'b1; wb_rd = 4'd7; wb_data = 32'h1234; step(); wb_en = 1'b0;
    chk("post_reset_ts", 64'(trace_cycle), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_trace_monitor.md
# wb_trace_monitor

Parametrised write-back trace monitor for the 5-stage pipelined CPU, instantiated beside `cpu_top` and driven from the write-back and fetch stages. It timestamps every register write-back into a circular trace FIFO, counts execution cycles, and ends a run on a branch-to-self halt or on a cycle-budget timeout. Benches read the trace through a first-word-fall-through pop interface, with no per-signal monitors needed.

## Interface
- `DATA_W`, 32, write-back data width
- `PC_W`, 32, program counter width
- `REG_W`, 4, register index width
- `DEPTH`, 16, trace FIFO entries (power of 2, ≥2)
- `CNT_W`, 16, cycle counter / timestamp / drop counter width
- `TIMEOUT`, 100, cycle budget per run (1 ≤ TIMEOUT < 2^CNT_W)
- `HALT_CYCLES`, 4, consecutive unchanged-PC cycles that count as a halt (≥1)

Ports:
- `clk` in 1: single clock; all logic is rising-edge
- `reset` in 1: asynchronous, active-high; clears everything
- `start` in 1: begin a run (IDLE only)
- `clr` in 1: synchronous clear back to IDLE
- `pc` in PC_W: fetch-stage PC
- `wb_en` in 1: write-back strobe
- `wb_rd` in REG_W: write-back register index
- `wb_data` in DATA_W: write-back value
- `trace_pop` in 1: consume head entry
- `trace_valid` out 1: FIFO non-empty
- `trace_cycle` out CNT_W: head timestamp
- `trace_rd` out REG_W: head register index
- `trace_data` out DATA_W: head data
- `trace_count` out $clog2(DEPTH)+1: occupancy
- `overflow` out 1: sticky, set when an entry is dropped
- `drop_cnt` out CNT_W: dropped entries, saturating
- `cycle_cnt` out CNT_W: cycles spent in RUN
- `state` out 2: IDLE=0, RUN=1, HALTED=2, TIMEOUT=3
- `done` out 1: state is HALTED or TIMEOUT

## Operation
- **Reset values:** state IDLE. All counters 0. `overflow` 0, `trace_valid` 0, FIFO empty. Trace data outputs are don't-care while `trace_valid` is 0.
- **Priority:** `reset` > `clr` > everything else. `clr` empties the FIFO, zeroes `cycle_cnt`, `drop_cnt`, `overflow` and the stable counter, and enters IDLE.
- **IDLE:**
  - On `start`, go to RUN.
  - No captures occur in IDLE.
  - `pc_q` registers `pc` every cycle; the stable counter is held at 0.
- **RUN:**
  - `cycle_cnt` increments each cycle and does not wrap; the TIMEOUT bound guarantees this.
  - When `wb_en` is 1, push {`cycle_cnt`, `wb_rd`, `wb_data`}.
  - **Halt detection:** if `pc == pc_q`, the stable counter increments; otherwise it resets to 0.
  - If `pc == pc_q` and the stable counter equals HALT_CYCLES-1, go to HALTED.
  - Otherwise, if `cycle_cnt == TIMEOUT-1`, go to TIMEOUT. HALTED wins when both hold on the same edge.
  - A push in the final RUN cycle is still captured.
- **HALTED / TIMEOUT:**
  - These states are terminal until `clr`; `start` is ignored.
  - No captures occur; `cycle_cnt` freezes.
  - The FIFO stays readable.
- **FIFO:**
  - Circular, with wrap-around read and write pointers.
  - Push when full and no pop: entry dropped, `overflow` set to 1, `drop_cnt` increments and saturates at 2^CNT_W-1.
  - Push and pop together when full: both take effect, nothing is dropped, count stays at DEPTH.
  - Push and pop together when non-empty and not full: count unchanged.
  - Pop when empty: ignored.
  - Head fields are shown combinationally from the read pointer.

## Timing
- Capture latency is 1 cycle. An entry pushed at edge N into an empty FIFO gives `trace_valid`=1 after edge N.
- Pop takes effect at the edge. The next entry, or `trace_valid`=0, is visible after that edge.
- `start` sampled at edge N: state is RUN after N. The first timestamp is 0. `cycle_cnt` reads k after k RUN edges.
- Timeout: the state becomes TIMEOUT after edge TIMEOUT-1 of the run, with `cycle_cnt`=TIMEOUT. The last possible timestamp is TIMEOUT-1.
- Halt: the PC held constant over HALT_CYCLES consecutive compare edges gives HALTED after the HALT_CYCLES-th edge.
- `reset` asserted mid-run clears all state immediately, without waiting for a clock edge.

## Test plan
- **Basic capture:** reset, start, `wb_en` on cycles 0, 2, 3 with rd=1, 2, 3 and data 0xA, 0xB, 0xC, then pop ×3. Head sequence must be (0,1,0xA), (2,2,0xB), (3,3,0xC), then `trace_valid`=0.
- **Overflow:** DEPTH=16, 18 consecutive pushes with no pop. Required: count=16, `overflow`=1, `drop_cnt`=2, head timestamp 0, last entry timestamp 15. Then push with pop on a full FIFO: count stays 16 and `drop_cnt` stays 2.
- **Halt:** PC increments by 4 until 0x20, then holds 0x20 with HALT_CYCLES=4. Required: HALTED 4 edges after the first repeat, `done`=1, and a `wb_en` applied afterwards is not captured.
- **Timeout:** TIMEOUT=100 with the PC always changing. Required: TIMEOUT state with `cycle_cnt`=100; a push on RUN cycle 99 is captured with stamp 99.
- **Halt/timeout tie:** arrange for the halt condition to complete on the same edge as cycle 99 with TIMEOUT=100. Required: state HALTED.
- **Clear and reset:** `clr` together with `start` gives IDLE with an empty FIFO and `overflow`=0. Asynchronous `reset` pulsed mid-run, between clock edges, gives all outputs at their reset values before the next edge.
